// File: rtl/alu_writeback_pkg.sv
// Shared types for the ALU writeback stage: condition codes, flag bit indices and the
// buffered entry layout.
package alu_writeback_pkg;

   localparam int unsigned WB_WIDTH  = 16;
   localparam int unsigned WB_ADDR_W = 3;

   localparam int unsigned FLAGS_Z = 0;
   localparam int unsigned FLAGS_C = 1;
   localparam int unsigned FLAGS_V = 2;
   localparam int unsigned FLAGS_N = 3;

   typedef enum logic [3:0] {
      CondAl = 4'd0,
      CondEq = 4'd1,
      CondNe = 4'd2,
      CondCs = 4'd3,
      CondCc = 4'd4,
      CondMi = 4'd5,
      CondPl = 4'd6,
      CondVs = 4'd7,
      CondVc = 4'd8,
      CondHi = 4'd9,
      CondLs = 4'd10,
      CondGe = 4'd11,
      CondLt = 4'd12,
      CondGt = 4'd13,
      CondLe = 4'd14,
      CondNv = 4'd15
   } cond_codes_t;

   typedef struct packed {
      logic [WB_WIDTH-1:0]  result;
      logic [3:0]           flags;
      logic [WB_ADDR_W-1:0] rd;
      logic                 we;
      logic                 set_flags;
   } wb_entry_t;

endpackage

// File: rtl/alu_writeback_fifo.sv
// Writeback entry FIFO: storage, wrapping pointers and occupancy count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module alu_writeback_fifo
   import alu_writeback_pkg::*;
#(
   parameter int unsigned DEPTH   = 2,
   parameter type         entry_t = wb_entry_t
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   push_i,
   input  logic   pop_i,
   input  entry_t wdata_i,
   output entry_t rdata_o,
   output logic   full_o,
   output logic   empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   entry_t              mem_q [DEPTH];
   logic   [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic   [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic   [CntW-1:0]   count_q, count_d;
   logic                push_ok, pop_ok;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: validity is tracked by count_q alone.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers results, drives the register-file write port, holds the
// status flags and evaluates branch conditions. Optional macro: FLAGS_BYPASS_EN.
module alu_writeback
   import alu_writeback_pkg::*;
#(
   parameter int unsigned WIDTH  = WB_WIDTH,
   parameter int unsigned ADDR_W = WB_ADDR_W,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [WIDTH-1:0]  in_result_i,
   input  logic [3:0]        in_flags_i,
   input  logic [ADDR_W-1:0] in_rd_i,
   input  logic              in_we_i,
   input  logic              in_set_flags_i,
   input  logic              out_ready_i,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] wb_addr_o,
   output logic [WIDTH-1:0]  wb_data_o,
   output logic [3:0]        status_flags_o,
   input  logic [3:0]        cond_code_i,
   output logic              cond_true_o
);

   wb_entry_t   in_entry, head;
   logic        full, empty, push, commit, load_flags;
   logic [3:0]  status_q, status_d, cond_flags;
   cond_codes_t cc;
   logic        fz, fc, fv, fn;

   assign in_entry = '{result: in_result_i, flags: in_flags_i, rd: in_rd_i,
                       we: in_we_i, set_flags: in_set_flags_i};

   // Ready depends only on state and reset, never on out_ready_i.
   assign in_ready_o = ~rst_i & ~full;
   assign push       = in_valid_i & in_ready_o;
   assign commit     = ~empty & (out_ready_i | ~head.we);
   assign load_flags = commit & head.set_flags;

   alu_writeback_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (wb_entry_t)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (commit),
      .wdata_i (in_entry),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign wb_we_o        = ~empty & head.we;
   assign wb_addr_o      = head.rd;
   assign wb_data_o      = head.result;
   assign status_flags_o = status_q;
   assign status_d       = load_flags ? head.flags : status_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) status_q <= '0;
      else       status_q <= status_d;
   end

`ifdef FLAGS_BYPASS_EN
   assign cond_flags = load_flags ? head.flags : status_q;
`else
   assign cond_flags = status_q;
`endif

   assign cc = cond_codes_t'(cond_code_i);
   assign fz = cond_flags[FLAGS_Z];
   assign fc = cond_flags[FLAGS_C];
   assign fv = cond_flags[FLAGS_V];
   assign fn = cond_flags[FLAGS_N];

   always_comb begin
      cond_true_o = 1'b0;
      unique case (cc)
         CondAl: cond_true_o = 1'b1;
         CondEq: cond_true_o = fz;
         CondNe: cond_true_o = ~fz;
         CondCs: cond_true_o = fc;
         CondCc: cond_true_o = ~fc;
         CondMi: cond_true_o = fn;
         CondPl: cond_true_o = ~fn;
         CondVs: cond_true_o = fv;
         CondVc: cond_true_o = ~fv;
         CondHi: cond_true_o = fc & ~fz;
         CondLs: cond_true_o = ~fc | fz;
         CondGe: cond_true_o = (fn == fv);
         CondLt: cond_true_o = (fn != fv);
         CondGt: cond_true_o = ~fz & (fn == fv);
         CondLe: cond_true_o = fz | (fn != fv);
         CondNv: cond_true_o = 1'b0;
         default: cond_true_o = 1'b0;
      endcase
   end

endmodule
